ad9516_spi_master: RTL and testbench



---
 rtl/ad9516_spi_master_if.sv | 27 ++
 rtl/ad9516_spi_master.sv | 144 ++++++++++++++
 tb/tb_ad9516_spi_master.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ad9516_spi_master_if.sv
// rtl/ad9516_spi_master_if.sv - command/response and SPI pin bundle for the AD9516 SPI engine
interface ad9516_spi_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [12:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_done;
  logic [7:0]  rsp_rdata;
  logic        busy;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_sdio;
  logic        spi_sdo;

  // Engine side.
  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, spi_sdo,
    output cmd_ready, rsp_done, rsp_rdata, busy, spi_sclk, spi_cs_n, spi_sdio
  );

  // Sequencer / device side.
  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, spi_sdo,
    input  cmd_ready, rsp_done, rsp_rdata, busy, spi_sclk, spi_cs_n, spi_sdio
  );
endinterface

// File: rtl/ad9516_spi_master.sv
// rtl/ad9516_spi_master.sv - AD9516 single-byte register read/write SPI engine
module ad9516_spi_master #(
  parameter int CLK_DIV  = 5,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic               sys_clk_i,
  input  logic               sys_rst_i,
  ad9516_spi_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [4:0]  bit_q;
  logic [23:0] shift_q;
  logic        rw_q;
  logic [7:0]  rx_q;
  logic [7:0]  rsp_rdata_q;
  logic        rsp_done_q;
  logic        cmd_ready_q;
  logic        busy_q;
  logic        sclk_q;
  logic        cs_n_q;
  logic        sdio_q;
  logic        sdo_meta_q;
  logic        sdo_sync_q;
  logic [23:0] cmd_word_d;

  // Instruction R/W, W1W0=00 (one byte), 13-bit address, then the data byte.
  assign cmd_word_d = {bus.cmd_rw, 2'b00, bus.cmd_addr, bus.cmd_rw ? 8'h00 : bus.cmd_wdata};

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      sdo_meta_q <= 1'b0;
      sdo_sync_q <= 1'b0;
    end else begin
      sdo_meta_q <= bus.spi_sdo;
      sdo_sync_q <= sdo_meta_q;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      rx_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_done_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sdio_q      <= 1'b0;
    end else begin
      rsp_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            state_q     <= SETUP;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cs_n_q      <= 1'b0;
            sdio_q      <= cmd_word_d[23];
            shift_q     <= cmd_word_d;
            rw_q        <= bus.cmd_rw;
            rx_q        <= '0;
            cnt_q       <= '0;
          end
        end
        SETUP: begin
          if (cnt_q == 16'(CS_SETUP - 1)) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        SHIFT: begin
          if (cnt_q != 16'(CLK_DIV - 1)) begin
            cnt_q <= cnt_q + 16'd1;
          end else begin
            cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // Last cycle of the high phase: sample readback, then fall and present the next bit.
              sclk_q <= 1'b0;
              if (rw_q && bit_q >= 5'd16) begin
                rx_q <= {rx_q[6:0], sdo_sync_q};
              end
              if (bit_q == 5'd23) begin
                state_q <= HOLD;
              end else begin
                bit_q   <= bit_q + 5'd1;
                shift_q <= {shift_q[22:0], shift_q[23]};
                sdio_q  <= shift_q[22];
              end
            end
          end
        end
        HOLD: begin
          if (cnt_q == 16'(CS_HOLD - 1)) begin
            state_q     <= GAP;
            cnt_q       <= '0;
            cs_n_q      <= 1'b1;
            sdio_q      <= 1'b0;
            rsp_done_q  <= 1'b1;
            rsp_rdata_q <= rw_q ? rx_q : 8'h00;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        GAP: begin
          if (cnt_q == 16'(CS_GAP - 1)) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_done  = rsp_done_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.spi_sclk  = sclk_q;
  assign bus.spi_cs_n  = cs_n_q;
  assign bus.spi_sdio  = sdio_q;

endmodule

// File: tb/tb_ad9516_spi_master.sv
// tb/tb_ad9516_spi_master.sv - directed scoreboard bench for ad9516_spi_master
module tb_ad9516_spi_master;
  localparam int DIV0 = 5;
  localparam int DIV1 = 3;
  localparam int L0   = 2 + 48 * DIV0 + 2;
  localparam int L1   = 2 + 48 * DIV1 + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ad9516_spi_master_if if0();
  ad9516_spi_master_if if1();

  ad9516_spi_master #(.CLK_DIV(DIV0)) dut0 (.sys_clk_i(clk), .sys_rst_i(rst), .bus(if0));
  ad9516_spi_master #(.CLK_DIV(DIV1)) dut1 (.sys_clk_i(clk), .sys_rst_i(rst), .bus(if1));

  logic       sclk_w[2], cs_w[2], sdio_w[2], ready_w[2], busy_w[2], done_w[2];
  logic [7:0] rdata_w[2];
  logic       sdo_r[2] = '{1'b0, 1'b0};

  assign sclk_w[0]  = if0.spi_sclk;  assign sclk_w[1]  = if1.spi_sclk;
  assign cs_w[0]    = if0.spi_cs_n;  assign cs_w[1]    = if1.spi_cs_n;
  assign sdio_w[0]  = if0.spi_sdio;  assign sdio_w[1]  = if1.spi_sdio;
  assign ready_w[0] = if0.cmd_ready; assign ready_w[1] = if1.cmd_ready;
  assign busy_w[0]  = if0.busy;      assign busy_w[1]  = if1.busy;
  assign done_w[0]  = if0.rsp_done;  assign done_w[1]  = if1.rsp_done;
  assign rdata_w[0] = if0.rsp_rdata; assign rdata_w[1] = if1.rsp_rdata;
  assign if0.spi_sdo = sdo_r[0];
  assign if1.spi_sdo = sdo_r[1];

  typedef struct {
    logic [23:0] word;
    logic [7:0]  rdata;
  } exp_t;
  exp_t sb[2][$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Device model and bus monitor, one lane per instance.
  logic [7:0]  dev[2]            = '{8'h00, 8'h00};
  logic        prev_sclk[2]      = '{1'b0, 1'b0};
  logic        prev_cs[2]        = '{1'b1, 1'b1};
  logic [23:0] cap[2]            = '{24'h0, 24'h0};
  int          rises[2]          = '{0, 0};
  int          cs_low[2]         = '{0, 0};
  int          cs_falls[2]       = '{0, 0};
  int          rise_cyc[2]       = '{0, 0};
  int          gap[2]            = '{0, 0};
  int          hrun[2]           = '{0, 0};
  int          lrun[2]           = '{0, 0};
  int          done_cnt[2]       = '{0, 0};
  int          done_cyc[2]       = '{0, 0};
  int          first_rise_cyc[2] = '{0, 0};

  always @(negedge clk) begin
    logic [23:0] c;
    int r, cl, h, l;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      c = cap[i]; r = rises[i]; cl = cs_low[i]; h = hrun[i]; l = lrun[i];
      if (prev_cs[i] && !cs_w[i]) begin
        c = '0; r = 0; cl = 0; h = 0; l = 0;
        cs_falls[i] <= cs_falls[i] + 1;
        gap[i]      <= cyc - rise_cyc[i];
        sdo_r[i]    <= 1'b0;
      end
      if (!prev_cs[i] && cs_w[i]) rise_cyc[i] <= cyc;
      if (!cs_w[i]) cl++;
      if (sclk_w[i] && !prev_sclk[i]) begin
        c = {c[22:0], sdio_w[i]};
        r++;
        if (r == 1) first_rise_cyc[i] <= cyc;
        if (i == 1 && r > 1) check("sclk_low_phase", l, DIV1);
      end
      if (!sclk_w[i] && prev_sclk[i]) begin
        if (i == 1) check("sclk_high_phase", h, DIV1);
        h = 0; l = 0;
        if (r >= 16 && r < 24) sdo_r[i] <= dev[i][7 - (r - 16)];
      end
      if (sclk_w[i]) h++; else l++;
      if (done_w[i]) begin
        done_cnt[i] <= done_cnt[i] + 1;
        done_cyc[i] <= cyc;
        check("rsp_done_expected", sb[i].size() > 0, 1);
        if (sb[i].size() > 0) begin
          e = sb[i].pop_front();
          check("sdio_word", c, e.word);
          check("sclk_rises", r, 24);
          check("rsp_rdata", rdata_w[i], e.rdata);
          check("cs_low_cycles", cl, (i == 0) ? L0 : L1);
        end
      end
      cap[i] <= c; rises[i] <= r; cs_low[i] <= cl; hrun[i] <= h; lrun[i] <= l;
      prev_sclk[i] <= sclk_w[i];
      prev_cs[i]   <= cs_w[i];
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic v, input logic rw, input logic [12:0] a, input logic [7:0] d);
    if (idx == 0) begin
      if0.cmd_valid = v; if0.cmd_rw = rw; if0.cmd_addr = a; if0.cmd_wdata = d;
    end else begin
      if1.cmd_valid = v; if1.cmd_rw = rw; if1.cmd_addr = a; if1.cmd_wdata = d;
    end
  endtask

  // Returns the accept cycle; on return the bench sits in the cycle after it.
  task automatic accept(input int idx, output int t);
    for (int k = 0; k < 2000; k++) begin
      if (ready_w[idx]) break;
      tick();
    end
    check("accept_ready", ready_w[idx], 1'b1);
    t = cyc;
    tick();
  endtask

  task automatic issue(input int idx, input logic rw, input logic [12:0] a, input logic [7:0] d, output int t);
    drive(idx, 1'b1, rw, a, d);
    accept(idx, t);
    drive(idx, 1'b0, 1'b0, 13'h0, 8'h0);
  endtask

  task automatic wait_idle(input int idx, output int t);
    for (int k = 0; k < 2000; k++) begin
      if (ready_w[idx]) break;
      tick();
    end
    check("idle_ready", ready_w[idx], 1'b1);
    t = cyc;
  endtask

  initial begin
    int t, t2, tr, d0, f0;
    drive(0, 1'b0, 1'b0, 13'h0, 8'h0);
    drive(1, 1'b0, 1'b0, 13'h0, 8'h0);
    repeat (4) tick();

    check("rst_cs_n", cs_w[0], 1'b1);
    check("rst_sclk", sclk_w[0], 1'b0);
    check("rst_sdio", sdio_w[0], 1'b0);
    check("rst_cmd_ready", ready_w[0], 1'b0);
    check("rst_busy", busy_w[0], 1'b0);
    check("rst_rsp_done", done_w[0], 1'b0);
    check("rst_rsp_rdata", rdata_w[0], 8'h00);
    rst = 1'b0;
    tick();
    check("ready_after_reset", ready_w[0], 1'b1);

    // Write 0x232 = 0x01 with full timing checks.
    sb[0].push_back('{24'h023201, 8'h00});
    issue(0, 1'b0, 13'h232, 8'h01, t);
    check("wr_busy_T1", busy_w[0], 1'b1);
    check("wr_ready_T1", ready_w[0], 1'b0);
    check("wr_cs_n_T1", cs_w[0], 1'b0);
    wait_idle(0, tr);
    check("wr_first_rise", first_rise_cyc[0] - t, 1 + 2 + DIV0);
    check("wr_done_cycle", done_cyc[0] - t, L0 + 1);
    check("wr_ready_cycle", tr - t, L0 + 1 + 4);

    // Read 0x000 with the device returning 0x18.
    dev[0] = 8'h18;
    sb[0].push_back('{24'h800000, 8'h18});
    issue(0, 1'b1, 13'h000, 8'h00, t);
    wait_idle(0, tr);

    // Back-to-back writes with cmd_valid held high.
    d0 = done_cnt[0];
    sb[0].push_back('{24'h00107C, 8'h00});
    sb[0].push_back('{24'h001101, 8'h00});
    drive(0, 1'b1, 1'b0, 13'h010, 8'h7C);
    accept(0, t);
    drive(0, 1'b1, 1'b0, 13'h011, 8'h01);
    accept(0, t2);
    drive(0, 1'b0, 1'b0, 13'h0, 8'h0);
    check("b2b_accept_spacing", t2 - t, L0 + 1 + 4);
    wait_idle(0, tr);
    // CS stays high through the GAP cycles plus the accept cycle of the next command.
    check("b2b_cs_high_cycles", gap[0], 4 + 1);
    check("b2b_done_count", done_cnt[0] - d0, 2);

    // cmd_valid pulse while busy is dropped.
    f0 = cs_falls[0];
    sb[0].push_back('{24'h00453C, 8'h00});
    issue(0, 1'b0, 13'h045, 8'h3C, t);
    while (cyc < t + 50) tick();
    check("busy_ready_low", ready_w[0], 1'b0);
    drive(0, 1'b1, 1'b0, 13'h0F0, 8'hAA);
    tick();
    drive(0, 1'b0, 1'b0, 13'h0, 8'h0);
    wait_idle(0, tr);
    repeat (20) tick();
    check("busy_cs_falls", cs_falls[0] - f0, 1);
    check("busy_sb_empty", sb[0].size(), 0);

    // Reset in the middle of a read.
    dev[0] = 8'h5A;
    d0 = done_cnt[0];
    issue(0, 1'b1, 13'h003, 8'h00, t);
    while (cyc < t + 100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_cs_n", cs_w[0], 1'b1);
    check("midrst_sclk", sclk_w[0], 1'b0);
    check("midrst_sdio", sdio_w[0], 1'b0);
    check("midrst_busy", busy_w[0], 1'b0);
    repeat (300) tick();
    check("midrst_no_done", done_cnt[0] - d0, 0);
    sb[0].push_back('{24'h023201, 8'h00});
    issue(0, 1'b0, 13'h232, 8'h01, t);
    wait_idle(0, tr);
    check("midrst_recover_done", done_cnt[0] - d0, 1);
    check("midrst_recover_ready", tr - t, L0 + 1 + 4);

    // Minimum divider read of 0xA5.
    dev[1] = 8'hA5;
    sb[1].push_back('{24'h800400, 8'hA5});
    issue(1, 1'b1, 13'h004, 8'h00, t);
    wait_idle(1, tr);
    check("div3_ready_cycle", tr - t, L1 + 1 + 4);
    check("div3_done_cycle", done_cyc[1] - t, L1 + 1);

    repeat (5) tick();
    check("sb0_drained", sb[0].size(), 0);
    check("sb1_drained", sb[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
